// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, RAM-port and stall signals around the unified memory arbiter.
// slave is the arbiter's view; master is the pipeline/RAM environment driving it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stall_pipe;
  logic        stall_fetch;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, ram_en, ram_we, ram_addr, ram_wdata,
    output stall_pipe, stall_fetch
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, ram_en, ram_we, ram_addr, ram_wdata,
    input  stall_pipe, stall_fetch
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by fetch and load/store; MEM wins ties, each access
// holds the RAM for MEM_LATENCY cycles followed by a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBusyMem,
    StBusyIf,
    StDoneMem,
    StDoneIf
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            if_ready_q;
  logic            mem_ready_q;
  logic [31:0]     if_rdata_q;
  logic [31:0]     mem_rdata_q;
  logic            ram_en_q;
  logic            ram_we_q;
  logic [31:0]     ram_addr_q;
  logic [31:0]     ram_wdata_q;

  // The ram_* registers double as the latched request: loaded on grant, cleared on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.mem_req) begin
            state_q     <= StBusyMem;
            cnt_q       <= CntInit;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.mem_we;
            ram_addr_q  <= bus.mem_addr;
            ram_wdata_q <= bus.mem_wdata;
          end else if (bus.if_req) begin
            state_q     <= StBusyIf;
            cnt_q       <= CntInit;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= bus.if_addr;
            ram_wdata_q <= '0;
          end
        end
        StBusyMem, StBusyIf: begin
          if (cnt_q == '0) begin
            if (state_q == StBusyIf) begin
              if_rdata_q <= bus.ram_rdata;
              if_ready_q <= 1'b1;
              state_q    <= StDoneIf;
            end else begin
              if (!ram_we_q) begin
                mem_rdata_q <= bus.ram_rdata;
              end
              mem_ready_q <= 1'b1;
              state_q     <= StDoneMem;
            end
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDoneMem, StDoneIf: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.if_ready    = if_ready_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.stall_pipe  = bus.mem_req & ~mem_ready_q;
  assign bus.stall_fetch = bus.if_req & ~if_ready_q & ~(bus.mem_req & ~mem_ready_q);
endmodule
